remote_comm: RTL and testbench

- Host-side command transmitter that mimics the remote controller for the quadcopter flight controller.
- Serialises a 3-byte command packet (cmd, data high byte, data low byte) over a built-in 8N1 UART transmitter.
- Receives the single-byte response (e.g. ACK 0xA5) from the flight controller over a built-in UART receiver.
- Used in system benches to drive the flight controller's RX pin and monitor its TX pin.

---
 rtl/remote_comm.sv | 212 +++++++++++++++++++++
 tb/tb_remote_comm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// remote_comm: host-side command transmitter that stands in for the quadcopter
// remote. It sends a 3-byte packet (cmd, data[15:8], data[7:0]) over an 8N1
// UART and receives single-byte responses on an independent UART receiver.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-HIGH (name kept for the codebase)
//   RX            serial input from the flight controller TX, idle high
//   TX            serial output to the flight controller RX, idle high
//   cmd, data     packet contents, latched when send_cmd is seen in IDLE
//   send_cmd      one-cycle start pulse, ignored while a packet is in flight
//   cmd_sent      set after the last stop bit, cleared by the next send_cmd
//   resp          last received byte
//   resp_rdy      resp holds an unconsumed byte
//   clr_resp_rdy  synchronous clear of resp_rdy (a same-cycle set wins)
module remote_comm #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        send_cmd,
   output logic        cmd_sent,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy
);

   localparam int unsigned       BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] SEND_CMD = 3'd1;
   localparam logic [2:0] SEND_HI  = 3'd2;
   localparam logic [2:0] SEND_LO  = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // transmit side
   logic [2:0]        tx_state, tx_state_nxt;
   logic [9:0]        tx_shift, tx_shift_nxt;
   logic [BAUD_W-1:0] tx_baud, tx_baud_nxt;
   logic [3:0]        tx_bit, tx_bit_nxt;
   logic [15:0]       data_q, data_q_nxt;
   logic              cmd_sent_nxt;

   // receive side
   logic              rx_s1, rx_s2, rx_prev;
   logic [1:0]        rx_state, rx_state_nxt;
   logic [BAUD_W-1:0] rx_baud, rx_baud_nxt;
   logic [3:0]        rx_bit, rx_bit_nxt;
   logic [7:0]        rx_shift, rx_shift_nxt;
   logic [7:0]        resp_nxt;
   logic              resp_rdy_nxt;
   logic              rdy_set, rdy_clr;

   // TX is the LSB of the frame shift register; it refills with ones so idle is high
   assign TX = tx_shift[0];

   // packet FSM: next state and datapath; the next byte loads on the edge the stop bit ends
   always_comb begin
      tx_state_nxt = tx_state;
      tx_shift_nxt = tx_shift;
      tx_baud_nxt  = tx_baud;
      tx_bit_nxt   = tx_bit;
      data_q_nxt   = data_q;
      cmd_sent_nxt = cmd_sent;
      case (tx_state)
         TX_IDLE: begin
            if (send_cmd) begin
               tx_state_nxt = SEND_CMD;
               data_q_nxt   = data;
               cmd_sent_nxt = 1'b0;
               tx_shift_nxt = {1'b1, cmd, 1'b0};
               tx_baud_nxt  = '0;
               tx_bit_nxt   = '0;
            end
         end
         SEND_CMD, SEND_HI, SEND_LO: begin
            if (tx_baud == BAUD_LAST) begin
               tx_baud_nxt = '0;
               if (tx_bit == 4'd9) begin
                  tx_bit_nxt = '0;
                  case (tx_state)
                     SEND_CMD: begin
                        tx_state_nxt = SEND_HI;
                        tx_shift_nxt = {1'b1, data_q[15:8], 1'b0};
                     end
                     SEND_HI: begin
                        tx_state_nxt = SEND_LO;
                        tx_shift_nxt = {1'b1, data_q[7:0], 1'b0};
                     end
                     default: begin
                        tx_state_nxt = DONE;
                        tx_shift_nxt = '1;
                     end
                  endcase
               end else begin
                  tx_bit_nxt   = tx_bit + 4'd1;
                  tx_shift_nxt = {1'b1, tx_shift[9:1]};
               end
            end else begin
               tx_baud_nxt = tx_baud + BAUD_W'(1);
            end
         end
         DONE: begin
            cmd_sent_nxt = 1'b1;
            tx_state_nxt = TX_IDLE;
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // receiver FSM: start detect, half-bit start re-check, mid-bit sampling
   always_comb begin
      rx_state_nxt = rx_state;
      rx_baud_nxt  = rx_baud;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      resp_nxt     = resp;
      rdy_set      = 1'b0;
      rdy_clr      = clr_resp_rdy;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s2) begin
               rx_state_nxt = RX_START;
               rx_baud_nxt  = '0;
               rdy_clr      = 1'b1;
            end
         end
         RX_START: begin
            if (rx_baud == HALF_LAST) begin
               rx_baud_nxt  = '0;
               rx_bit_nxt   = '0;
               // a line that is high again by mid-start was only a glitch
               rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
               rx_baud_nxt = rx_baud + BAUD_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_baud == BAUD_LAST) begin
               rx_baud_nxt  = '0;
               rx_shift_nxt = {rx_s2, rx_shift[7:1]};
               if (rx_bit == 4'd7) rx_state_nxt = RX_STOP;
               else                rx_bit_nxt   = rx_bit + 4'd1;
            end else begin
               rx_baud_nxt = rx_baud + BAUD_W'(1);
            end
         end
         RX_STOP: begin
            // stop-bit level is deliberately not checked
            if (rx_baud == BAUD_LAST) begin
               rx_baud_nxt  = '0;
               resp_nxt     = rx_shift;
               rdy_set      = 1'b1;
               rx_state_nxt = RX_IDLE;
            end else begin
               rx_baud_nxt = rx_baud + BAUD_W'(1);
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
      resp_rdy_nxt = rdy_set ? 1'b1 : (rdy_clr ? 1'b0 : resp_rdy);
   end

   // state registers for both directions
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tx_state <= TX_IDLE;
         tx_shift <= '1;
         tx_baud  <= '0;
         tx_bit   <= '0;
         data_q   <= '0;
         cmd_sent <= 1'b0;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_baud  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         resp     <= '0;
         resp_rdy <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         tx_shift <= tx_shift_nxt;
         tx_baud  <= tx_baud_nxt;
         tx_bit   <= tx_bit_nxt;
         data_q   <= data_q_nxt;
         cmd_sent <= cmd_sent_nxt;
         rx_s1    <= RX;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_nxt;
         rx_baud  <= rx_baud_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_shift <= rx_shift_nxt;
         resp     <= resp_nxt;
         resp_rdy <= resp_rdy_nxt;
      end
   end

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: self-checking bench for remote_comm. Expected bytes come from
// the packet rule (cmd, data high, data low) and from the bytes the bench itself
// drives onto RX; the TX line is decoded by a bit-level UART sampler.
module tb_remote_comm;

   localparam int BAUD_DIV = 434;
   localparam int HALF     = BAUD_DIV / 2;

   logic        clk          = 1'b0;
   logic        rst_n        = 1'b1;
   logic        rx_tb        = 1'b1;
   logic        loopback     = 1'b0;
   logic        send_cmd     = 1'b0;
   logic        clr_resp_rdy = 1'b0;
   logic [7:0]  cmd          = 8'h00;
   logic [15:0] data         = 16'h0000;
   logic        TX, cmd_sent, resp_rdy, rx_line;
   logic [7:0]  resp;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   assign rx_line = loopback ? TX : rx_tb;

   remote_comm #(.BAUD_DIV(BAUD_DIV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .RX           (rx_line),
      .TX           (TX),
      .cmd          (cmd),
      .data         (data),
      .send_cmd     (send_cmd),
      .cmd_sent     (cmd_sent),
      .resp         (resp),
      .resp_rdy     (resp_rdy),
      .clr_resp_rdy (clr_resp_rdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // decode one 8N1 frame from TX by mid-bit sampling
   task automatic cap_tx_byte(output logic [7:0] b, output logic frame_ok);
      int   n;
      logic st, sp;
      b        = 8'h00;
      frame_ok = 1'b0;
      n        = 0;
      while (TX !== 1'b0 && n < 3 * BAUD_DIV) begin
         @(negedge clk);
         n++;
      end
      if (TX !== 1'b0) return;
      repeat (HALF) @(negedge clk);
      st = TX;
      for (int i = 0; i < 8; i++) begin
         repeat (BAUD_DIV) @(negedge clk);
         b[i] = TX;
      end
      repeat (BAUD_DIV) @(negedge clk);
      sp       = TX;
      frame_ok = (st === 1'b0) && (sp === 1'b1);
   endtask

   // drive one frame onto RX and check delivery just after the mid-stop sample
   task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
      rx_tb = 1'b0;
      repeat (20) @(negedge clk);
      check("rdy_clr_on_start", 32'(resp_rdy), 32'd0);
      repeat (BAUD_DIV - 20) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_tb = b[i];
         repeat (BAUD_DIV) @(negedge clk);
      end
      rx_tb = stop_bit;
      repeat (HALF + 20) @(negedge clk);
      check("rx_rdy_set", 32'(resp_rdy), 32'd1);
      check("rx_resp", 32'(resp), 32'(b));
      rx_tb = 1'b1;
      repeat (BAUD_DIV - HALF - 20) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [15:0] d, input logic perturb);
      logic [7:0] exp_b [3];
      logic [7:0] got;
      logic       fok, seen;
      int         t0, lat, n;
      exp_b[0] = c;
      exp_b[1] = d[15:8];
      exp_b[2] = d[7:0];
      @(negedge clk);
      cmd      = c;
      data     = d;
      send_cmd = 1'b1;
      @(negedge clk);
      send_cmd = 1'b0;
      t0       = cyc;
      check("cmd_sent_clr", 32'(cmd_sent), 32'd0);
      if (perturb) begin
         cmd  = 8'($urandom);
         data = 16'($urandom);
      end
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               cap_tx_byte(got, fok);
               check("tx_byte", 32'(got), 32'(exp_b[k]));
               check("tx_frame", 32'(fok), 32'd1);
            end
         end
         begin
            if (perturb) begin
               repeat (3000) @(negedge clk);
               cmd      = 8'($urandom);
               data     = 16'($urandom);
               send_cmd = 1'b1;
               @(negedge clk);
               send_cmd = 1'b0;
               repeat (5000) @(negedge clk);
               cmd  = ~c;
               data = ~d;
            end
         end
         begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 14000) begin
               @(negedge clk);
               n++;
               if (cmd_sent === 1'b1) seen = 1'b1;
            end
            lat = cyc - t0;
            check("cmd_sent_seen", 32'(seen), 32'd1);
            check("cmd_sent_window", 32'((lat >= 13020) && (lat <= 13026)), 32'd1);
         end
      join
      repeat (100) @(negedge clk);
      check("cmd_sent_hold", 32'(cmd_sent), 32'd1);
      check("tx_idle", 32'(TX), 32'd1);
   endtask

   logic [7:0] lb_exp [3];
   logic [7:0] r_byte, resp_before;
   logic       tx_stayed;
   int         n_wait;

   initial begin
      // reset values
      repeat (5) @(negedge clk);
      check("rst_tx", 32'(TX), 32'd1);
      check("rst_cmd_sent", 32'(cmd_sent), 32'd0);
      check("rst_resp", 32'(resp), 32'd0);
      check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);

      // response byte, then clear
      drive_rx(8'hA5, 1'b1);
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
      @(negedge clk);
      check("clr_rdy", 32'(resp_rdy), 32'd0);
      check("clr_resp_kept", 32'(resp), 32'hA5);

      // random bytes: second follows without a clear, third has a bad stop bit
      r_byte = 8'($urandom);
      drive_rx(r_byte, 1'b1);
      r_byte = 8'($urandom);
      drive_rx(r_byte, 1'b1);
      r_byte = 8'($urandom);
      drive_rx(r_byte, 1'b0);

      // short low glitch is rejected
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
      resp_before  = resp;
      rx_tb = 1'b0;
      repeat (100) @(negedge clk);
      rx_tb = 1'b1;
      repeat (1000) @(negedge clk);
      check("glitch_rdy", 32'(resp_rdy), 32'd0);
      check("glitch_resp", 32'(resp), 32'(resp_before));

      // packets on TX
      send_pkt(8'h05, 16'h00FF, 1'b0);
      send_pkt(8'h03, 16'hFF80, 1'b1);

      // loopback: the receiver must see the packet bytes in order
      loopback  = 1'b1;
      lb_exp[0] = 8'h06;
      lb_exp[1] = 8'h00;
      lb_exp[2] = 8'h00;
      @(negedge clk);
      cmd      = 8'h06;
      data     = 16'h0000;
      send_cmd = 1'b1;
      @(negedge clk);
      send_cmd = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_wait = 0;
         while (resp_rdy !== 1'b1 && n_wait < 6000) begin
            @(negedge clk);
            n_wait++;
         end
         check("lb_rdy", 32'(resp_rdy), 32'd1);
         check("lb_byte", 32'(resp), 32'(lb_exp[k]));
         if (k < 2) begin
            repeat (300) @(negedge clk);
            check("lb_rdy_reclr", 32'(resp_rdy), 32'd0);
         end
      end
      n_wait = 0;
      while (cmd_sent !== 1'b1 && n_wait < 1000) begin
         @(negedge clk);
         n_wait++;
      end
      check("lb_cmd_sent", 32'(cmd_sent), 32'd1);
      loopback = 1'b0;
      repeat (10) @(negedge clk);

      // asynchronous reset in the middle of a start bit
      cmd      = 8'h5A;
      data     = 16'($urandom);
      send_cmd = 1'b1;
      @(negedge clk);
      send_cmd = 1'b0;
      repeat (200) @(negedge clk);
      check("pre_rst_tx_low", 32'(TX), 32'd0);
      #1 rst_n = 1'b1;
      #1;
      check("arst_tx", 32'(TX), 32'd1);
      check("arst_cmd_sent", 32'(cmd_sent), 32'd0);
      check("arst_resp_rdy", 32'(resp_rdy), 32'd0);
      check("arst_resp", 32'(resp), 32'd0);
      @(negedge clk);
      rst_n     = 1'b0;
      tx_stayed = 1'b1;
      repeat (1500) begin
         @(negedge clk);
         if (TX !== 1'b1) tx_stayed = 1'b0;
      end
      check("no_resume", 32'(tx_stayed), 32'd1);
      check("no_resume_cmd_sent", 32'(cmd_sent), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
